mem_arbiter: RTL

- Shares one single-port synchronous unified RAM between the core's instruction-fetch port and its load/store data port.
- Sits between franken_riscv-style core ports and the memory macro. It replaces separate instruction and data memories.
- Grants one request per cycle and returns read data one cycle later.
- Drives a stall output so the core can freeze its PC and register writes while it waits.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_pick.sv | 72 +++++++
 rtl/mem_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter.
//   owner_e    : which port owns the response slot in the cycle after a grant
//   last_gnt_e : winner of the most recent fetch/data conflict
//   wait_inc   : saturating increment for the fetch starvation counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  typedef enum logic {
    LAST_IF = 1'b0,
    LAST_D  = 1'b1
  } last_gnt_e;

  localparam int WAIT_W = 4;

  function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] cnt,
                                                 input logic [WAIT_W-1:0] max_cnt);
    return (cnt >= max_cnt) ? max_cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the fetch and data requesters.
// Holds the fetch starvation counter and the round-robin history.
//   clk, reset      : clock, synchronous active-low reset
//   if_req, d_req   : requests from the fetch and data ports
//   if_gnt, d_gnt   : one-hot (or zero) grant, combinational from the requests
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int PRIO_DATA = 1,
  parameter int MAX_WAIT  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic d_req,
  output logic if_gnt,
  output logic d_gnt
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  last_gnt_e         last_gnt_q, last_gnt_d;
  logic              conflict;

  assign conflict = if_req & d_req;

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (reset) begin
      if (conflict) begin
        // Starvation guard overrides both priority and round-robin.
        if (wait_cnt_q == MAX_WAIT_C) begin
          if_gnt = 1'b1;
        end else if (PRIO_DATA != 0) begin
          d_gnt = 1'b1;
        end else if (last_gnt_q == LAST_D) begin
          if_gnt = 1'b1;
        end else begin
          d_gnt = 1'b1;
        end
      end else begin
        if_gnt = if_req;
        d_gnt  = d_req;
      end
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if (if_req && !if_gnt) begin
      wait_cnt_d = wait_inc(wait_cnt_q, MAX_WAIT_C);
    end
    // History only moves on a real contest; uncontested grants leave it alone.
    last_gnt_d = last_gnt_q;
    if (conflict) begin
      last_gnt_d = if_gnt ? LAST_IF : LAST_D;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      last_gnt_q <= LAST_D;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and
// load/store data. One grant per cycle, read data one cycle after the grant.
//   clk, reset              : clock, synchronous active-low reset
//   if_req/if_addr          : fetch request and byte address
//   if_gnt/if_rvalid/if_rdata : fetch accept, response valid, response data
//   d_req/d_we/d_be/d_addr/d_wdata : data request, store flag, lanes, addr, data
//   d_gnt/d_rvalid/d_rdata  : data accept, load data / store ack, load data
//   mem_*                   : RAM macro interface, mem_rdata valid the cycle after mem_en
//   stall                   : some request is pending and not granted this cycle
//
// owner register:
//   state    | meaning
//   OWN_NONE | no access issued last cycle, no response due
//   OWN_IF   | fetch issued last cycle, mem_rdata goes to the fetch port
//   OWN_D    | data access issued last cycle, load data or store ack due
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_DATA = 1,
  parameter int MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  owner_e owner_q, owner_d;
  logic   owner_we_q, owner_we_d;

  mem_arb_pick #(
    .PRIO_DATA (PRIO_DATA),
    .MAX_WAIT  (MAX_WAIT)
  ) u_pick (
    .clk    (clk),
    .reset  (reset),
    .if_req (if_req),
    .d_req  (d_req),
    .if_gnt (if_gnt),
    .d_gnt  (d_gnt)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_be   = 4'b1111;
      mem_addr = if_addr & WORD_MASK;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr & WORD_MASK;
      mem_wdata = d_wdata;
    end
  end

  always_comb begin
    owner_d    = OWN_NONE;
    owner_we_d = 1'b0;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt) begin
      owner_d    = OWN_D;
      owner_we_d = d_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_q    <= OWN_NONE;
      owner_we_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      owner_we_q <= owner_we_d;
    end
  end

  // Responses are gated by reset so an access in flight when reset hits
  // never produces a response.
  always_comb begin
    if_rvalid = reset && (owner_q == OWN_IF);
    d_rvalid  = reset && (owner_q == OWN_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = (d_rvalid && !owner_we_q) ? mem_rdata : '0;
    stall     = reset && ((if_req && !if_gnt) || (d_req && !d_gnt));
  end

endmodule
